// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_pkg
// Brief   : Shared NoC router types: flit types, port indices, FSM states.
// Revision: 1.0
// ============================================================================
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_HEAD      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  localparam int P_N       = 0;
  localparam int P_S       = 1;
  localparam int P_W       = 2;
  localparam int P_E       = 3;
  localparam int P_L       = 4;
  localparam int NUM_PORTS = 5;

  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_GRANT = 2'd1,
    S_XFER       = 2'd2,
    S_RELEASE    = 2'd3
  } state_e;

  // Isolates the lowest set bit so a multi-bit grant picks the lowest port.
  function automatic logic [NUM_PORTS-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
    return v & (~v + {{(NUM_PORTS-1){1'b0}}, 1'b1});
  endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// Module  : flit_fifo
// Brief   : Power-of-two flit FIFO with wrap-bit pointers; no push bypass.
// Revision: 1.0
// ============================================================================
module flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  // Full when the low bits match but the wrap bits differ.
  assign full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                 (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign head  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/input_port_controller.sv
`default_nettype none
// ============================================================================
// Module  : input_port_controller
// Brief   : Per-input-port requester: buffers flits, requests a next hop,
//           streams the granted packet to the crossbar, then releases.
// Revision: 1.0
// ============================================================================
module input_port_controller
  import noc_pkg::*;
#(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              flit_valid_i,
  output logic              flit_ready_o,
  output logic [7:0]        addr_header_o,
  output logic              nhr_write_o,
  input  logic [4:0]        grant_i,
  output logic [FLIT_W-1:0] xbar_flit_o,
  output logic              xbar_valid_o,
  output logic [4:0]        xbar_sel_o,
  input  logic              xbar_ready_i,
  output logic [4:0]        change_order_o,
  output logic              error_o
);

  state_e            r_state;
  state_e            w_next_state;
  logic [4:0]        r_sel;
  logic [4:0]        w_next_sel;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [FLIT_W-1:0] w_head;
  flit_type_e        w_head_type;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (flit_valid_i),
    .push_data (flit_i),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign w_head_type   = flit_type_e'(w_head[FLIT_W-1:FLIT_W-2]);
  assign flit_ready_o  = !w_full;
  assign addr_header_o = w_empty ? 8'h00 : w_head[ADDR_MSB:ADDR_LSB];
  assign xbar_sel_o    = r_sel;
  assign xbar_flit_o   = xbar_valid_o ? w_head : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_sel     = r_sel;
    w_pop          = 1'b0;
    nhr_write_o    = 1'b0;
    error_o        = 1'b0;
    xbar_valid_o   = 1'b0;
    change_order_o = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head_type == FT_HEAD || w_head_type == FT_HEAD_TAIL) begin
            nhr_write_o  = 1'b1;
            w_next_state = S_WAIT_GRANT;
          end else begin
            // Orphan BODY/TAIL with no header: discard and flag it.
            w_pop   = 1'b1;
            error_o = 1'b1;
          end
        end
      end
      S_WAIT_GRANT: begin
        if (grant_i != 5'b0) begin
          w_next_sel   = lowest_set(grant_i);
          w_next_state = S_XFER;
        end
      end
      S_XFER: begin
        xbar_valid_o = !w_empty;
        if (xbar_valid_o && xbar_ready_i) begin
          w_pop = 1'b1;
          if (w_head_type == FT_TAIL || w_head_type == FT_HEAD_TAIL)
            w_next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        change_order_o = r_sel;
        w_next_sel     = '0;
        w_next_state   = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_port_controller
// Brief   : Directed self-checking bench for input_port_controller.
// Revision: 1.0
// ============================================================================
module tb_input_port_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] flit_i;
  logic        flit_valid_i;
  logic        flit_ready_o;
  logic [7:0]  addr_header_o;
  logic        nhr_write_o;
  logic [4:0]  grant_i;
  logic [31:0] xbar_flit_o;
  logic        xbar_valid_o;
  logic [4:0]  xbar_sel_o;
  logic        xbar_ready_i;
  logic [4:0]  change_order_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_port_controller #(.FLIT_W(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .flit_i         (flit_i),
    .flit_valid_i   (flit_valid_i),
    .flit_ready_o   (flit_ready_o),
    .addr_header_o  (addr_header_o),
    .nhr_write_o    (nhr_write_o),
    .grant_i        (grant_i),
    .xbar_flit_o    (xbar_flit_o),
    .xbar_valid_o   (xbar_valid_o),
    .xbar_sel_o     (xbar_sel_o),
    .xbar_ready_i   (xbar_ready_i),
    .change_order_o (change_order_o),
    .error_o        (error_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs for a cycle are set just after the falling edge, outputs checked 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ready"},  {31'b0, flit_ready_o}, 32'd1);
    check({tag, " addr"},   {24'b0, addr_header_o}, 32'h0);
    check({tag, " nhr"},    {31'b0, nhr_write_o}, 32'd0);
    check({tag, " xvalid"}, {31'b0, xbar_valid_o}, 32'd0);
    check({tag, " xflit"},  xbar_flit_o, 32'h0);
    check({tag, " sel"},    {27'b0, xbar_sel_o}, 32'h0);
    check({tag, " chg"},    {27'b0, change_order_o}, 32'h0);
    check({tag, " err"},    {31'b0, error_o}, 32'd0);
  endtask

  logic [31:0] pkt [4];
  int pushed, xfers, chgs;

  initial begin
    reset = 1'b1; flit_i = '0; flit_valid_i = 1'b0; grant_i = '0; xbar_ready_i = 1'b0;
    tick(); tick(); #1;
    check_quiet("reset");
    reset = 1'b0;

    // ---------------- single-flit packet ----------------
    tick(); flit_valid_i = 1'b1; flit_i = 32'hC000_0012; #1;
    check("t1 ready c0", {31'b0, flit_ready_o}, 32'd1);
    tick(); flit_valid_i = 1'b0; #1;
    check("t1 nhr c1", {31'b0, nhr_write_o}, 32'd1);
    check("t1 addr c1", {24'b0, addr_header_o}, 32'h12);
    tick(); grant_i = 5'b00100; #1;
    check("t1 nhr c2", {31'b0, nhr_write_o}, 32'd0);
    check("t1 xvalid c2", {31'b0, xbar_valid_o}, 32'd0);
    tick(); grant_i = 5'b0; xbar_ready_i = 1'b1; #1;
    check("t1 xvalid c3", {31'b0, xbar_valid_o}, 32'd1);
    check("t1 sel c3", {27'b0, xbar_sel_o}, 32'b00100);
    check("t1 xflit c3", xbar_flit_o, 32'hC000_0012);
    check("t1 chg c3", {27'b0, change_order_o}, 32'h0);
    tick(); #1;
    check("t1 chg c4", {27'b0, change_order_o}, 32'b00100);
    check("t1 xvalid c4", {31'b0, xbar_valid_o}, 32'd0);
    tick(); #1;
    check("t1 chg c5", {27'b0, change_order_o}, 32'h0);
    check("t1 sel c5", {27'b0, xbar_sel_o}, 32'h0);

    // ---------------- 4-flit packet, ready on odd cycles ----------------
    pkt[0] = 32'h4000_0034; pkt[1] = 32'h0000_1111;
    pkt[2] = 32'h0000_2222; pkt[3] = 32'h8000_3333;
    pushed = 0; xfers = 0; chgs = 0;
    grant_i = 5'b00001;
    for (int i = 0; i < 24; i++) begin
      tick();
      flit_valid_i = (pushed < 4);
      flit_i       = (pushed < 4) ? pkt[pushed] : 32'h0;
      xbar_ready_i = i[0];
      #1;
      if (change_order_o != 5'b0) begin
        chgs++;
        check("t2 chg value", {27'b0, change_order_o}, 32'b00001);
        check("t2 chg after tail", xfers, 4);
      end
      if (xbar_valid_o && xbar_ready_i) begin
        check("t2 xfer flit", xbar_flit_o, (xfers < 4) ? pkt[xfers] : 32'hDEAD_BEEF);
        check("t2 xfer sel", {27'b0, xbar_sel_o}, 32'b00001);
        xfers++;
      end
      if (flit_valid_i && flit_ready_o) pushed++;
    end
    check("t2 xfer count", xfers, 4);
    check("t2 chg count", chgs, 1);
    flit_valid_i = 1'b0; grant_i = '0; xbar_ready_i = 1'b0;

    // ---------------- orphan BODY flit ----------------
    tick(); flit_valid_i = 1'b1; flit_i = 32'h0000_0ABC; #1;
    tick(); flit_valid_i = 1'b0; #1;
    check("t3 err c1", {31'b0, error_o}, 32'd1);
    check("t3 nhr c1", {31'b0, nhr_write_o}, 32'd0);
    tick(); #1;
    check("t3 err c2", {31'b0, error_o}, 32'd0);
    check("t3 addr empty", {24'b0, addr_header_o}, 32'h0);
    check("t3 nhr c2", {31'b0, nhr_write_o}, 32'd0);

    // ---------------- fill FIFO, multi-bit grant, back-to-back ----------------
    pkt[0] = 32'h4000_0056; pkt[1] = 32'h0000_AAAA;
    pkt[2] = 32'h0000_BBBB; pkt[3] = 32'h8000_CCCC;
    for (int i = 0; i < 4; i++) begin
      tick(); flit_valid_i = 1'b1; flit_i = pkt[i]; #1;
      check("t4 ready filling", {31'b0, flit_ready_o}, 32'd1);
    end
    tick(); flit_i = 32'hC000_0078; #1;
    check("t4 full c4", {31'b0, flit_ready_o}, 32'd0);
    tick(); grant_i = 5'b10010; #1;
    check("t4 full c5", {31'b0, flit_ready_o}, 32'd0);
    check("t4 xvalid c5", {31'b0, xbar_valid_o}, 32'd0);
    tick(); grant_i = 5'b01000; xbar_ready_i = 1'b1; #1;
    check("t4 sel c6", {27'b0, xbar_sel_o}, 32'b00010);
    check("t4 xflit c6", xbar_flit_o, pkt[0]);
    check("t4 full c6", {31'b0, flit_ready_o}, 32'd0);
    tick(); #1;
    check("t4 ready c7", {31'b0, flit_ready_o}, 32'd1);
    check("t4 xflit c7", xbar_flit_o, pkt[1]);
    tick(); flit_valid_i = 1'b0; #1;
    check("t4 xflit c8", xbar_flit_o, pkt[2]);
    check("t4 sel c8", {27'b0, xbar_sel_o}, 32'b00010);
    tick(); #1;
    check("t4 xflit c9", xbar_flit_o, pkt[3]);
    tick(); grant_i = 5'b0; #1;
    check("t4 chg c10", {27'b0, change_order_o}, 32'b00010);
    check("t4 nhr c10", {31'b0, nhr_write_o}, 32'd0);
    tick(); #1;
    check("t4 nhr c11", {31'b0, nhr_write_o}, 32'd1);
    check("t4 addr c11", {24'b0, addr_header_o}, 32'h78);
    check("t4 chg c11", {27'b0, change_order_o}, 32'h0);
    tick(); grant_i = 5'b00001; #1;
    tick(); grant_i = 5'b0; #1;
    check("t4 ht xvalid", {31'b0, xbar_valid_o}, 32'd1);
    check("t4 ht sel", {27'b0, xbar_sel_o}, 32'b00001);
    check("t4 ht xflit", xbar_flit_o, 32'hC000_0078);
    tick(); #1;
    check("t4 ht chg", {27'b0, change_order_o}, 32'b00001);
    tick(); xbar_ready_i = 1'b0; #1;

    // ---------------- reset mid-XFER ----------------
    pkt[0] = 32'h4000_009A; pkt[1] = 32'h0000_0001;
    pkt[2] = 32'h0000_0002; pkt[3] = 32'h8000_0004;
    grant_i = 5'b01000; xbar_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); flit_valid_i = 1'b1; flit_i = pkt[i]; #1;
      if (i == 3) check("t5 xflit c3", xbar_flit_o, pkt[0]);
    end
    tick(); flit_valid_i = 1'b0; #1;
    check("t5 xflit c4", xbar_flit_o, pkt[1]);
    tick(); reset = 1'b1; #1;
    check_quiet("t5 async reset");
    tick(); #1;
    check_quiet("t5 held reset");
    reset = 1'b0; grant_i = '0; xbar_ready_i = 1'b0;
    tick(); flit_valid_i = 1'b1; flit_i = 32'h4000_00DE; #1;
    check("t5 nhr push cycle", {31'b0, nhr_write_o}, 32'd0);
    tick(); flit_valid_i = 1'b0; #1;
    check("t5 nhr after reset", {31'b0, nhr_write_o}, 32'd1);
    check("t5 addr after reset", {24'b0, addr_header_o}, 32'hDE);
    tick(); #1;
    check("t5 nhr single", {31'b0, nhr_write_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
